// File: rtl/la_uart_pkg.sv
// Shared types and constants for the LA-driven UART transmitter.
// No logic of its own; imported by la_uart_fifo and la_uart_tx.
// Backpressure: not applicable.
package la_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        STOP_LEVEL = 1'b1;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/la_uart_fifo.sv
// Synchronous byte FIFO with occupancy count; head word is read combinationally.
// Latency: a push is visible at the head one clock later.
// Backpressure: full_o is derived from registered state only; push while full is dropped.
module la_uart_fifo
    import la_uart_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 8,
    parameter int LEVEL_W = 3
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic               pop_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LEVEL_W-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               do_push, do_pop;

    assign full_o  = (level_q == LEVEL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) level_d = level_q + 1'b1;
        if (do_pop && !do_push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/la_uart_tx.sv
// 8N1 UART transmitter fed through a byte FIFO; LA_UART_TX_PARITY_EN adds an even-parity bit.
// Latency: byte accepted at edge N leaves the FIFO at N+1 with the start bit driven from N+1.
// Backpressure: tx_ready = FIFO not full, registered; frames back-to-back while tx_en and data remain.
module la_uart_tx
    import la_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    parameter int LEVEL_W    = 3
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               tx_en,
    input  logic [DIV_W-1:0]   clk_div,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               uart_tx,
    output logic               tx_busy,
    output logic               tx_done,
    output logic [LEVEL_W-1:0] fifo_level
);

    uart_state_e      state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic             line_q, line_d;
`ifdef LA_UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic       fifo_full, fifo_empty, pop;
    logic [7:0] fifo_rdata;
    logic       bit_end, start_ok;

    la_uart_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (8),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clock   (clock),
        .resetb  (resetb),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign tx_ready = !fifo_full;
    assign uart_tx  = line_q;
    assign tx_busy  = (state_q != ST_IDLE);
    assign bit_end  = (cnt_q == div_q);
    assign start_ok = tx_en && !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        div_d   = div_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        line_d  = line_q;
        pop     = 1'b0;
        tx_done = 1'b0;
`ifdef LA_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                pop   = start_ok;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    line_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef LA_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        line_d  = par_q;
`else
                        state_d = ST_STOP;
                        line_d  = STOP_LEVEL;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        line_d  = shift_q[1];
                    end
                end
            end
`ifdef LA_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    line_d  = STOP_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                tx_done = bit_end;
                if (bit_end) begin
                    pop = start_ok;
                    if (!start_ok) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        line_d  = IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                line_d  = IDLE_LEVEL;
            end
        endcase

        // Frame start, from IDLE or straight out of STOP: divisor is sampled only here.
        if (pop) begin
            state_d = ST_START;
            cnt_d   = '0;
            div_d   = clk_div;
            shift_d = fifo_rdata;
            idx_d   = '0;
            line_d  = 1'b0;
`ifdef LA_UART_TX_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            line_q  <= IDLE_LEVEL;
`ifdef LA_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
`ifdef LA_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_la_uart_tx.sv
// Randomised scoreboard bench for la_uart_tx: accepted bytes are queued with their divisor,
// a line monitor rebuilds each frame from the UART rules and compares every clock.
module tb_la_uart_tx;

    localparam int DIV_W   = 16;
    localparam int LEVEL_W = 3;
    localparam int DEPTH   = 4;
`ifdef LA_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic               clock    = 1'b0;
    logic               resetb   = 1'b1;
    logic               tx_en    = 1'b0;
    logic               tx_valid = 1'b0;
    logic [DIV_W-1:0]   clk_div  = 16'd3;
    logic [7:0]         tx_data  = 8'h00;
    logic               tx_ready, uart_tx, tx_busy, tx_done;
    logic [LEVEL_W-1:0] fifo_level;

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   mon_starts[$];
    int   mon_ends[$];
    logic mon_active = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    la_uart_tx #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DIV_W),
        .LEVEL_W    (LEVEL_W)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .tx_en      (tx_en),
        .clk_div    (clk_div),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected line level at sample k of a frame carrying byte b with divisor d.
    function automatic logic exp_line(input logic [7:0] b, input int d, input int k);
        int bitno;
        bitno = k / (d + 1);
        if (bitno == 0) return 1'b0;
        if (bitno <= 8) return b[bitno-1];
        if (NBITS == 11 && bitno == 9) return ^b;
        return 1'b1;
    endfunction

    // Line monitor / scoreboard checker.
    initial begin
        exp_t       cur;
        int         k, bad, len, bitno;
        logic [7:0] dec;
        cur = '0; k = 0; bad = 0; len = 0; dec = '0;
        forever begin
            @(negedge clock);
            if (!resetb) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && uart_tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: line low with no byte expected (cycle %0d)", cyc);
                    end else begin
                        cur = exp_q.pop_front();
                        mon_active = 1'b1;
                        k = 0;
                        bad = 0;
                        dec = '0;
                        len = (int'(cur.d) + 1) * NBITS;
                        mon_starts.push_back(cyc);
                    end
                end
                if (mon_active) begin
                    if (uart_tx !== exp_line(cur.b, int'(cur.d), k)) bad++;
                    if (tx_done !== (k == len - 1)) bad++;
                    if (tx_busy !== 1'b1) bad++;
                    bitno = k / (int'(cur.d) + 1);
                    if (k % (int'(cur.d) + 1) == int'(cur.d) / 2 && bitno >= 1 && bitno <= 8)
                        dec[bitno-1] = uart_tx;
                    k++;
                    if (k == len) begin
                        chk("frame_wave", bad, 0);
                        chk("frame_byte", {24'd0, dec}, {24'd0, cur.b});
                        mon_ends.push_back(cyc);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, output int waited);
        tx_data  = b;
        tx_valid = 1'b1;
        waited   = 0;
        while (tx_ready !== 1'b1 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        if (tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: tx_ready stuck at %b, expected 1", tx_ready);
        end else begin
            exp_q.push_back('{b: b, d: clk_div});
        end
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || mon_active) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk(name, n >= 5000, 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || fifo_level !== '0 || mon_active || exp_q.size() != 0) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk(name, n >= 5000, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [4];
        int w, peak, ready_drop, s0, span, lows, n;
        b2b = '{8'h55, 8'h0F, 8'hFF, 8'h00};

        // Asynchronous reset before any clock edge.
        #1 resetb = 1'b0;
        #2;
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_fifo_level", fifo_level, 0);
        @(negedge clock);
        @(negedge clock);
        resetb = 1'b1;
        tx_en  = 1'b1;
        @(negedge clock);

        // Single byte and first-transaction latency.
        clk_div  = 16'd3;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        exp_q.push_back('{b: 8'hA5, d: clk_div});
        @(negedge clock);
        tx_valid = 1'b0;
        chk("lat_line_high", uart_tx, 1);
        chk("lat_level_one", fifo_level, 1);
        @(negedge clock);
        chk("lat_line_low", uart_tx, 0);
        chk("lat_busy", tx_busy, 1);
        chk("lat_level_zero", fifo_level, 0);
        wait_idle("single_timeout");
        chk("single_busy_low", tx_busy, 0);

        // Back-to-back frames.
        s0 = mon_starts.size();
        peak = 0;
        ready_drop = 0;
        for (int i = 0; i < 4; i++) begin
            push(b2b[i], w);
            if (w != 0) ready_drop++;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        wait_idle("b2b_timeout");
        chk("b2b_peak_level", peak, 3);
        chk("b2b_ready_drops", ready_drop, 0);
        chk("b2b_frames", mon_ends.size() - s0, 4);
        span = (mon_ends.size() >= s0 + 4) ? (mon_ends[s0+3] - mon_starts[s0] + 1) : -1;
        chk("b2b_span", span, 4 * 4 * NBITS);

        // Full FIFO with transmission disabled.
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) push(8'($urandom), w);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("full_ready_low", tx_ready, 0);
        chk("full_level", fifo_level, 4);
        chk("full_idle", tx_busy, 0);
        tx_en = 1'b1;
        @(negedge clock);
        chk("full_ready_rise", tx_ready, 1);
        chk("full_level_pop", fifo_level, 3);
        exp_q.push_back('{b: 8'hC3, d: clk_div});
        @(negedge clock);
        tx_valid = 1'b0;
        chk("full_level_refill", fifo_level, 4);
        wait_idle("full_timeout");

        // Divisor change mid-frame.
        clk_div = 16'd3;
        push(8'h3C, w);
        repeat (12) @(negedge clock);
        clk_div = 16'd7;
        push(8'hE1, w);
        wait_idle("div_timeout");

        // Enable dropped mid-frame: frame completes, next byte waits.
        clk_div = 16'd2;
        push(8'h96, w);
        repeat (5) @(negedge clock);
        tx_en    = 1'b0;
        tx_data  = 8'h69;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        wait_quiet("en_off_timeout");
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        chk("en_off_quiet", lows, 0);
        chk("en_off_level", fifo_level, 1);
        exp_q.push_back('{b: 8'h69, d: clk_div});
        tx_en = 1'b1;
        wait_idle("en_on_timeout");

        // Reset during data bit 4.
        clk_div = 16'd3;
        push(8'hEF, w);
        push(8'h81, w);
        repeat (21) @(negedge clock);
        #2 resetb = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_line", uart_tx, 1);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        @(negedge clock);
        @(negedge clock);
        resetb = 1'b1;
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        chk("post_rst_quiet", lows, 0);

`ifdef LA_UART_TX_PARITY_EN
        clk_div = 16'd3;
        push(8'h07, w);
        wait_idle("par07_timeout");
        chk("par07_len", mon_ends[$] - mon_starts[$] + 1, 44);
        push(8'h03, w);
        wait_idle("par03_timeout");
        chk("par03_len", mon_ends[$] - mon_starts[$] + 1, 44);
`endif

        // Randomised bursts with random divisors and gaps.
        for (int it = 0; it < 8; it++) begin
            clk_div = 16'($urandom_range(0, 4));
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                push(8'($urandom), w);
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
            wait_idle("rand_timeout");
        end

        chk("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
